cache_wb_buffer: RTL and testbench

Write-back buffer between the L1 cache (upstream) and physical memory (downstream). Absorbs evicted dirty lines in one cycle so the cache miss path is not serialised behind the write-back. It drains them to memory when no read is pending and keeps read-after-write ordering per line address. Upstream it presents the same line-wide pmem handshake the cache already drives, so it drops in without changes to the cache.

---
 rtl/lc3b_types.sv | 23 ++
 rtl/wbbuf_store.sv | 87 ++++++++
 rtl/cache_wb_buffer.sv | 131 +++++++++++++
 tb/tb_cache_wb_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b line/word types plus write-back buffer state and entry types
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RESP
    } wbbuf_state_t;

    typedef struct packed {
        logic [11:0] tag;
        lc3b_line    data;
    } wbbuf_entry_t;

    function automatic lc3b_word tag_to_addr(input logic [11:0] tag);
        return {tag, 4'b0000};
    endfunction

endpackage

// File: rtl/wbbuf_store.sv
// rtl/wbbuf_store.sv - FIFO-ordered line store with per-line address match, overwrite and pop
module wbbuf_store
    import lc3b_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [11:0]  lookup_tag,
    output logic         hit,
    output lc3b_line     hit_data,
    output logic         full,
    output logic         empty,
    input  logic         enq,
    input  logic [11:0]  enq_tag,
    input  lc3b_line     enq_data,
    input  logic         ovw,
    input  lc3b_line     ovw_data,
    input  logic         pop,
    output wbbuf_entry_t head_entry
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wbbuf_entry_t     entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] hit_onehot;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Coalescing upstream keeps at most one valid entry per tag, so OR-ing is a clean mux.
    always_comb begin
        hit_onehot = '0;
        hit_data   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].tag == lookup_tag) begin
                hit_onehot[i] = 1'b1;
                hit_data      = hit_data | entries[i].data;
            end
        end
    end

    assign hit        = |hit_onehot;
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign head_entry = entries[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= next_ptr(tail);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= next_ptr(head);
            end
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ovw && hit_onehot[i]) begin
                entries[i].data <= ovw_data;
            end else if (enq && tail == PW'(i)) begin
                entries[i] <= '{tag: enq_tag, data: enq_data};
            end
        end
    end

endmodule

// File: rtl/cache_wb_buffer.sv
// rtl/cache_wb_buffer.sv - write-back buffer between L1 and pmem; WB_BUF_FWD_EN serves read hits from the buffer
module cache_wb_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  cache_address,
    input  logic [127:0] cache_wdata,
    input  logic         cache_read,
    input  logic         cache_write,
    output logic [127:0] cache_rdata,
    output logic         cache_resp,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    wbbuf_state_t state;
    wbbuf_entry_t head_entry;
    lc3b_line     hit_data;
    logic         hit;
    logic         full;
    logic         empty;
    logic         accept_wb;
    logic         start_read;
    logic         start_drain;
    logic         fwd_hit;
    logic         unused_addr_low;

    assign unused_addr_low = ^cache_address[3:0];

    wbbuf_store #(.DEPTH(DEPTH)) u_store (
        .clk        (clk),
        .reset      (reset),
        .lookup_tag (cache_address[15:4]),
        .hit        (hit),
        .hit_data   (hit_data),
        .full       (full),
        .empty      (empty),
        .enq        (accept_wb && !hit),
        .enq_tag    (cache_address[15:4]),
        .enq_data   (cache_wdata),
        .ovw        (accept_wb && hit),
        .ovw_data   (cache_wdata),
        .pop        (state == DRAIN && pmem_resp),
        .head_entry (head_entry)
    );

    // IDLE arbitration: write-backs first, then reads, then opportunistic draining.
    always_comb begin
        accept_wb   = 1'b0;
        start_read  = 1'b0;
        start_drain = 1'b0;
        fwd_hit     = 1'b0;
        if (state == IDLE) begin
            if (cache_write) begin
                if (hit || !full) accept_wb = 1'b1;
                else              start_drain = 1'b1;
            end else if (cache_read) begin
                if (!hit) begin
                    start_read = 1'b1;
                end else begin
`ifdef WB_BUF_FWD_EN
                    fwd_hit = 1'b1;
`else
                    start_drain = 1'b1;
`endif
                end
            end else if (!empty) begin
                start_drain = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cache_resp   <= 1'b0;
            cache_rdata  <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_wb || fwd_hit) begin
                        state       <= RESP;
                        cache_resp  <= 1'b1;
                        cache_rdata <= fwd_hit ? hit_data : '0;
                    end else if (start_read) begin
                        state        <= READ;
                        pmem_read    <= 1'b1;
                        pmem_address <= {cache_address[15:4], 4'b0000};
                    end else if (start_drain) begin
                        state        <= DRAIN;
                        pmem_write   <= 1'b1;
                        pmem_address <= tag_to_addr(head_entry.tag);
                        pmem_wdata   <= head_entry.data;
                    end
                end
                READ: begin
                    if (pmem_resp) begin
                        state       <= RESP;
                        pmem_read   <= 1'b0;
                        cache_resp  <= 1'b1;
                        cache_rdata <= pmem_rdata;
                    end
                end
                DRAIN: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_write <= 1'b0;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    cache_resp  <= 1'b0;
                    cache_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_wb_buffer.sv
// tb/tb_cache_wb_buffer.sv - directed self-checking bench for cache_wb_buffer with a latency-programmable memory
module tb_cache_wb_buffer;

    localparam logic [127:0] LA = {4{32'hAAAA_0001}};
    localparam logic [127:0] LB = {4{32'hBBBB_0002}};
    localparam logic [127:0] LC = {4{32'hCCCC_0003}};
    localparam logic [127:0] LD = {4{32'hDDDD_0004}};
    localparam logic [127:0] LE = {4{32'hEEEE_0005}};
    localparam logic [127:0] LF = {4{32'hF0F0_0006}};
    localparam logic [127:0] LG = {4{32'h9191_0007}};
    localparam logic [127:0] LH = {4{32'h1212_0008}};
    localparam logic [127:0] LJ = {4{32'h3434_0009}};
    localparam logic [127:0] LK = {4{32'h5656_000A}};
    localparam logic [127:0] LL = {4{32'h7878_000B}};

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  cache_address;
    logic [127:0] cache_wdata;
    logic         cache_read;
    logic         cache_write;
    logic [127:0] cache_rdata;
    logic         cache_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mem_lat = 0;
    logic [127:0] mem_line = '0;
    bit overlap = 1'b0;

    logic [16:0]  ev_q [$];
    logic [127:0] wd_q [$];
    int           st_q [$];
    int           rs_q [$];

    cache_wb_buffer #(.DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .cache_address (cache_address),
        .cache_wdata   (cache_wdata),
        .cache_read    (cache_read),
        .cache_write   (cache_write),
        .cache_rdata   (cache_rdata),
        .cache_resp    (cache_resp),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ev_at(input int i);
        return (i < ev_q.size()) ? ev_q[i] : '1;
    endfunction

    function automatic logic [127:0] wd_at(input int i);
        return (i < wd_q.size()) ? wd_q[i] : '1;
    endfunction

    task automatic clear_log;
        ev_q.delete();
        wd_q.delete();
        st_q.delete();
        rs_q.delete();
    endtask

    task automatic cache_req(input logic wr, input logic [15:0] addr, input logic [127:0] data,
                             output int t0, output int lat, output logic [127:0] rdata);
        @(negedge clk);
        cache_write   = wr;
        cache_read    = ~wr;
        cache_address = addr;
        cache_wdata   = data;
        t0  = cyc;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cache_resp && lat < 200);
        chk("cache_resp_seen", cache_resp, 1'b1);
        rdata       = cache_rdata;
        cache_write = 1'b0;
        cache_read  = 1'b0;
    endtask

    task automatic wait_drain_start;
        int w = 0;
        while (!pmem_write && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("drain_started", pmem_write, 1'b1);
    endtask

    // Memory: answers each held request after mem_lat extra cycles and logs {is_write, address}.
    initial begin : mem_model
        int cnt;
        int start;
        bit busy;
        cnt = 0;
        start = 0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (pmem_read && pmem_write) overlap = 1'b1;
            if (reset) begin
                pmem_resp = 1'b0;
                busy = 1'b0;
                cnt = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    start = cyc;
                end
                if (cnt >= mem_lat) begin
                    pmem_resp = 1'b1;
                    busy = 1'b0;
                    if (pmem_read) pmem_rdata = mem_line;
                    ev_q.push_back({pmem_write, pmem_address});
                    wd_q.push_back(pmem_wdata);
                    st_q.push_back(start);
                    rs_q.push_back(cyc);
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        int t0;
        int lat;
        logic [127:0] rd;

        cache_read = 1'b0;
        cache_write = 1'b0;
        cache_address = '0;
        cache_wdata = '0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cache_resp", cache_resp, 1'b0);
        chk("rst_cache_rdata", cache_rdata, 128'd0);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, 16'h0000);
        reset = 1'b0;

        // Single write-back, then autonomous drain.
        mem_lat = 2;
        clear_log();
        cache_req(1'b1, 16'h1230, LA, t0, lat, rd);
        chk("wb_lat", lat, 1);
        chk("wb_rdata_zero", rd, 128'd0);
        repeat (12) @(negedge clk);
        chk("wb_drain_count", ev_q.size(), 1);
        chk("wb_drain_addr", ev_at(0), {1'b1, 16'h1230});
        chk("wb_drain_data", wd_at(0), LA);
        chk("wb_drain_after_resp", (st_q.size() > 0) && (st_q[0] > t0 + 1) && (st_q[0] <= t0 + 3), 1'b1);
        repeat (10) @(negedge clk);
        chk("wb_buffer_empty", ev_q.size(), 1);

        // Coalesce then full: fourth write must wait for a drain of the coalesced head.
        mem_lat = 3;
        clear_log();
        cache_req(1'b1, 16'h1000, LA, t0, lat, rd);
        chk("coal_a_lat", lat, 1);
        cache_req(1'b1, 16'h2000, LB, t0, lat, rd);
        chk("coal_b_lat", lat, 1);
        cache_req(1'b1, 16'h1000, LC, t0, lat, rd);
        chk("coal_c_lat", lat, 1);
        chk("coal_c_no_drain", ev_q.size(), 0);
        cache_req(1'b1, 16'h3000, LD, t0, lat, rd);
        chk("full_d_lat", lat, 6);
        chk("full_d_drains", ev_q.size(), 1);
        chk("full_drain0_addr", ev_at(0), {1'b1, 16'h1000});
        chk("full_drain0_data", wd_at(0), LC);
        repeat (40) @(negedge clk);
        chk("full_drain_total", ev_q.size(), 3);
        chk("full_drain1_addr", ev_at(1), {1'b1, 16'h2000});
        chk("full_drain1_data", wd_at(1), LB);
        chk("full_drain2_addr", ev_at(2), {1'b1, 16'h3000});
        chk("full_drain2_data", wd_at(2), LD);

        // Read miss on empty buffer.
        mem_lat = 5;
        mem_line = LE;
        clear_log();
        cache_req(1'b0, 16'h4000, '0, t0, lat, rd);
        chk("miss_rdata", rd, LE);
        chk("miss_pmem_addr", ev_at(0), {1'b0, 16'h4000});
        chk("miss_read_start", (st_q.size() > 0) && (st_q[0] == t0 + 1), 1'b1);
        chk("miss_resp_after_pmem", (rs_q.size() > 0) && (t0 + lat == rs_q[0] + 1), 1'b1);
        chk("miss_lat", lat, 7);
        @(negedge clk);
        chk("miss_resp_one_cycle", cache_resp, 1'b0);

        // Read-after-write to a buffered line.
        repeat (3) @(negedge clk);
        mem_lat = 2;
        mem_line = LG;
        clear_log();
        cache_req(1'b1, 16'h5000, LF, t0, lat, rd);
        chk("raw_wb_lat", lat, 1);
        cache_req(1'b0, 16'h5000, '0, t0, lat, rd);
`ifdef WB_BUF_FWD_EN
        chk("raw_fwd_lat", lat, 1);
        chk("raw_fwd_rdata", rd, LF);
        chk("raw_fwd_no_pmem", ev_q.size(), 0);
        repeat (20) @(negedge clk);
        chk("raw_fwd_later_drain", ev_at(0), {1'b1, 16'h5000});
`else
        chk("raw_lat", lat, 8);
        chk("raw_rdata", rd, LG);
        chk("raw_drain_addr", ev_at(0), {1'b1, 16'h5000});
        chk("raw_drain_data", wd_at(0), LF);
        chk("raw_then_read", ev_at(1), {1'b0, 16'h5000});
`endif

        // Read arriving while another line is draining.
        repeat (20) @(negedge clk);
        mem_lat = 6;
        mem_line = LJ;
        clear_log();
        cache_req(1'b1, 16'h7000, LH, t0, lat, rd);
        wait_drain_start();
        cache_req(1'b0, 16'h6000, '0, t0, lat, rd);
        chk("mid_rdata", rd, LJ);
        chk("mid_events", ev_q.size(), 2);
        chk("mid_drain_first", ev_at(0), {1'b1, 16'h7000});
        chk("mid_drain_data", wd_at(0), LH);
        chk("mid_read_second", ev_at(1), {1'b0, 16'h6000});

        // Reset during an active drain discards the buffered line.
        repeat (5) @(negedge clk);
        mem_lat = 20;
        clear_log();
        cache_req(1'b1, 16'h8000, LK, t0, lat, rd);
        wait_drain_start();
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_pmem_write", pmem_write, 1'b0);
        chk("rstmid_pmem_read", pmem_read, 1'b0);
        chk("rstmid_cache_resp", cache_resp, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        mem_lat = 1;
        mem_line = LL;
        clear_log();
        cache_req(1'b0, 16'h8000, '0, t0, lat, rd);
        chk("rstmid_read_rdata", rd, LL);
        chk("rstmid_events", ev_q.size(), 1);
        chk("rstmid_read_from_mem", ev_at(0), {1'b0, 16'h8000});

        repeat (5) @(negedge clk);
        chk("no_rw_overlap", overlap, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
